// File: rtl/store_monitor_pkg.sv
// Shared types and constants for the store monitor and its debug log.
package store_monitor_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    PASS    = 2'b01,
    FAIL    = 2'b10,
    TIMEOUT = 2'b11
  } mon_state_t;

  localparam int unsigned MON_LOG_DEPTH = 4;
  localparam int unsigned MON_PTR_W     = $clog2(MON_LOG_DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;

endpackage

// File: rtl/store_monitor_if.sv
// Processor store bus as seen by the monitor.
interface store_monitor_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;

  modport master (output memwrite, output dataadr, output writedata);
  modport slave  (input  memwrite, input  dataadr, input  writedata);
endinterface

// File: rtl/store_log.sv
// Circular buffer of recent stores; read index 0 is the oldest retained entry.
module store_log
  import store_monitor_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 we,
  input  logic [31:0]          wr_addr,
  input  logic [31:0]          wr_data,
  input  logic [MON_PTR_W-1:0] rd_idx,
  output logic [31:0]          rd_addr,
  output logic [31:0]          rd_data
);

  log_entry_t           mem [MON_LOG_DEPTH];
  logic [MON_PTR_W-1:0] wptr;
  logic [MON_PTR_W-1:0] rd_phys;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      for (int unsigned i = 0; i < MON_LOG_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wptr] <= '{addr: wr_addr, data: wr_data};
      wptr      <= wptr + 1'b1;
    end
  end

  // wptr points at the oldest entry once the buffer has wrapped; the pointer width wraps mod depth.
  always_comb begin
    rd_phys = wptr + rd_idx;
    rd_addr = mem[rd_phys].addr;
    rd_data = mem[rd_phys].data;
  end

endmodule

// File: rtl/store_monitor.sv
// Classifies processor stores into a sticky RUN/PASS/FAIL/TIMEOUT verdict with cycle/store counters.
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter logic [31:0] RESULT_ADDR  = 32'd84,
  parameter logic [31:0] SCRATCH_ADDR = 32'd80,
  parameter logic [31:0] EXPECTED     = 32'hFFFF7F02,
  parameter int unsigned CYCLE_LIMIT  = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  store_monitor_if.slave       bus,
  input  logic [MON_PTR_W-1:0] log_idx,
  output mon_state_t           status,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           cycle_count,
  output logic [7:0]           store_count,
  output logic [31:0]          log_addr,
  output logic [31:0]          log_data
);

  localparam logic [7:0] LIMIT_LAST = 8'(CYCLE_LIMIT - 1);

  logic       accept;
  mon_state_t next_status;

  // A terminating store on the limit edge takes precedence over the timeout.
  always_comb begin
    accept      = bus.memwrite && (status == RUN);
    next_status = status;
    if (status == RUN) begin
      if (accept && (bus.dataadr == RESULT_ADDR)) begin
        next_status = (bus.writedata == EXPECTED) ? PASS : FAIL;
      end else if (accept && (bus.dataadr != SCRATCH_ADDR)) begin
        next_status = FAIL;
      end else if (cycle_count == LIMIT_LAST) begin
        next_status = TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status      <= RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      cycle_count <= '0;
      store_count <= '0;
    end else begin
      status <= next_status;
      done   <= (next_status != RUN);
      pass   <= (next_status == PASS);
      if (status == RUN) begin
        cycle_count <= cycle_count + 8'd1;
      end
      if (accept && (store_count != 8'hFF)) begin
        store_count <= store_count + 8'd1;
      end
    end
  end

  store_log u_log (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (accept),
    .wr_addr (bus.dataadr),
    .wr_data (bus.writedata),
    .rd_idx  (log_idx),
    .rd_addr (log_addr),
    .rd_data (log_data)
  );

endmodule

// File: doc/store_monitor.md
# store_monitor

Synthesizable data-memory bus monitor that sits directly downstream of the single-cycle MIPS `top` and consumes its `memwrite`/`dataadr`/`writedata` store bus. It classifies every store against a result address, a scratch address and an expected value, and records a sticky RUN/PASS/FAIL/TIMEOUT verdict. It also counts cycles and stores, and keeps a 4-entry circular log of recent stores for debug readout. This replaces ad-hoc bench checking with a reusable block that can also drive board LEDs.

## Interface
- `RESULT_ADDR`, default 84: store address that terminates the test.
- `SCRATCH_ADDR`, default 80: store address that is permitted and non-terminating.
- `EXPECTED`, default 32'hFFFF7F02 (-33022): required data at `RESULT_ADDR`.
- `CYCLE_LIMIT`, default 20: number of RUN cycles before timeout; legal range 1..255.
- Ports, one per line:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  reset; asynchronous and active-low.
- `memwrite`  in  1  store strobe from the processor.
- `dataadr`  in  32  store byte address.
- `writedata`  in  32  store data.
- `log_idx`  in  2  log read index; 0 = oldest retained entry, 3 = newest.
- `status`  out  2  verdict, encoded as `mon_state_t`.
- `done`  out  1  `status != RUN`.
- `pass`  out  1  `status == PASS`.
- `cycle_count`  out  8  number of RUN cycles elapsed.
- `store_count`  out  8  number of accepted stores; saturates at 255.
- `log_addr`  out  32  address of the selected log entry; combinational read.
- `log_data`  out  32  data of the selected log entry; combinational read.

## Operation
- Reset values, all asynchronous:
  - `status` = RUN, so `done` = 0 and `pass` = 0.
  - `cycle_count` = 0, `store_count` = 0.
  - Write pointer = 0; all log entries = 0.
- A store is sampled on a rising edge with `memwrite` = 1 while in RUN.
- Store classification, in priority order:
  - `dataadr == RESULT_ADDR` and `writedata == EXPECTED` -> PASS.
  - `dataadr == RESULT_ADDR` with any other data -> FAIL.
  - `dataadr == SCRATCH_ADDR` -> remain in RUN.
  - Any other address -> FAIL.
- Comparisons are on the full 32 bits. X or Z bits are not special-cased in RTL.
- Every accepted store in RUN, including the terminating one:
  - writes {addr, data} at the write pointer;
  - increments the write pointer modulo 4;
  - increments `store_count` unless it is already 255.
- `cycle_count` increments on every rising edge in RUN. It does not increment in terminal states.
- Timeout fires when, in RUN, `cycle_count == CYCLE_LIMIT - 1` and no terminating store occurs that edge. The transition goes to TIMEOUT and `cycle_count` becomes `CYCLE_LIMIT`.
- Simultaneous store and timeout: a terminating store on the limit edge wins (PASS or FAIL). A scratch store on that edge is logged and TIMEOUT still fires.
- Terminal states (PASS, FAIL, TIMEOUT) are sticky until `reset_n` is asserted. In a terminal state:
  - further stores are ignored, not logged and not counted;
  - all counters freeze.
- Log readout maps `log_idx` to physical entry `(wptr + log_idx) mod 4`. Before 4 stores have occurred, the low indices show reset zeros.
- Reset mid-operation clears everything immediately, independent of `clk`. The first store that can be sampled is on the first rising edge after `reset_n` deasserts.

## Timing
- Verdict latency: one edge. `status` reflects a store sampled at edge N from just after edge N onward.
- No handshake and no backpressure. The monitor never stalls the processor.
- Bus inputs must be stable around the rising edge, which holds for the single-cycle core's combinational store outputs.
- `log_addr`/`log_data` follow `log_idx` combinationally, with zero-cycle read latency from registered storage.
- All other outputs are registered.

## Structure
- Shared package `store_monitor_pkg` holds:
  - `typedef enum logic [1:0] mon_state_t {RUN=2'b00, PASS=2'b01, FAIL=2'b10, TIMEOUT=2'b11}`;
  - the log depth constant `MON_LOG_DEPTH = 4` and its pointer width.
- One natural sub-module: `store_log`, a 4x64-bit circular buffer. It has a write enable, a wrapping pointer and an indexed combinational read. The FSM and counters live in `store_monitor`.

## Test plan
- Reset, then scratch stores m[80]=5 and m[80]=7, then m[84]=-33022 -> `status` = PASS one edge later, `store_count` = 3, `log_idx` = 3 gives {84, 32'hFFFF7F02}.
- Store m[84]=7 -> FAIL; a later store m[84]=-33022 does not change `status`, and `store_count` stays 1.
- Store m[88]=1 -> FAIL; `log_addr` at index 3 = 88.
- No stores for 20 edges -> TIMEOUT exactly after the 20th edge, `cycle_count` = 20, `done` = 1, `pass` = 0.
- m[84]=-33022 on the 20th edge -> PASS, not TIMEOUT. Repeat with m[80] on that edge -> TIMEOUT, with the store logged.
- Six m[80] stores with data 1..6 -> log indices 0..3 read data 3,4,5,6. Drop `reset_n` mid-sequence, asynchronously -> all outputs return to reset values before the next edge.
